// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
//   Buffers one retirement record per cycle from writeback and presents the
//   records, oldest first, to the simulation trace sink. It counts consumed
//   records that were not killed. Once an illegal instruction has been
//   accepted, it stops taking new records, drains the queue and then halts.
//
// Parameters
//   DEPTH  queue entries (power of two, >= 2)
//   CNT_W  width of the retired-instruction counter
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   wb_valid / wb_ready    writeback record handshake
//   wb_inst, wb_dnpc,      record fields: instruction word, next PC,
//   wb_kill, wb_invalid,   flushed/bubble slot, illegal instruction,
//   wb_device              MMIO access
//   tr_valid / tr_ready    sink handshake for the head record
//   tr_*                   head record fields, qualified by tr_valid
//   retired_cnt            consumed records with kill clear (wraps)
//   halted                 illegal instruction consumed and queue empty
module commit_trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [31:0]      wb_inst,
    input  logic [63:0]      wb_dnpc,
    input  logic             wb_kill,
    input  logic             wb_invalid,
    input  logic             wb_device,
    output logic             tr_valid,
    input  logic             tr_ready,
    output logic [31:0]      tr_inst,
    output logic [63:0]      tr_dnpc,
    output logic             tr_kill,
    output logic             tr_invalid,
    output logic             tr_device,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] dnpc;
        logic        kill;
        logic        invalid;
        logic        device;
    } entry_t;

    state_t      state;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    entry_t      mem [DEPTH];
    entry_t      head;

    logic empty;
    logic full;
    logic push;
    logic pop;

    // Extra MSB on each pointer distinguishes full from empty when the
    // index bits coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Ready is a function of start-of-cycle state only, so a same-cycle pop
    // never opens room for a push into a full queue.
    assign wb_ready = !full && (state == RUN);
    assign tr_valid = !empty && (state != HALTED);

    assign push = wb_valid && wb_ready;
    assign pop  = tr_valid && tr_ready;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign tr_inst    = head.inst;
    assign tr_dnpc    = head.dnpc;
    assign tr_kill    = head.kill;
    assign tr_invalid = head.invalid;
    assign tr_device  = head.device;

    // Storage needs no reset: nothing is read unless the pointers say so.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{inst:    wb_inst,
                                     dnpc:    wb_dnpc,
                                     kill:    wb_kill,
                                     invalid: wb_invalid,
                                     device:  wb_device};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            state       <= RUN;
            retired_cnt <= '0;
            halted      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                if (!head.kill) begin
                    retired_cnt <= retired_cnt + CNT_ONE;
                end
            end

            case (state)
                RUN: begin
                    // The illegal record itself is accepted this cycle.
                    if (push && wb_invalid) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Empty seen at start of cycle: halt on this edge.
                    if (empty) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_trace_fifo.sv
module tb_commit_trace_fifo;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] dnpc;
        logic        kill;
        logic        invalid;
        logic        device;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_inst = '0;
    logic [63:0] wb_dnpc = '0;
    logic        wb_kill = 1'b0;
    logic        wb_invalid = 1'b0;
    logic        wb_device = 1'b0;
    logic        tr_ready = 1'b0;

    // Instance a: DEPTH=8 for the directed steps.
    logic        wb_ready_a, tr_valid_a, tr_kill_a, tr_invalid_a, tr_device_a, halted_a;
    logic [31:0] tr_inst_a;
    logic [63:0] tr_dnpc_a, retired_cnt_a;
    // Instance b: DEPTH=4 for the randomized phase.
    logic        wb_ready_b, tr_valid_b, tr_kill_b, tr_invalid_b, tr_device_b, halted_b;
    logic [31:0] tr_inst_b;
    logic [63:0] tr_dnpc_b, retired_cnt_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    commit_trace_fifo #(.DEPTH(8), .CNT_W(64)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready_a),
        .wb_inst(wb_inst), .wb_dnpc(wb_dnpc), .wb_kill(wb_kill),
        .wb_invalid(wb_invalid), .wb_device(wb_device),
        .tr_valid(tr_valid_a), .tr_ready(tr_ready),
        .tr_inst(tr_inst_a), .tr_dnpc(tr_dnpc_a), .tr_kill(tr_kill_a),
        .tr_invalid(tr_invalid_a), .tr_device(tr_device_a),
        .retired_cnt(retired_cnt_a), .halted(halted_a)
    );

    commit_trace_fifo #(.DEPTH(4), .CNT_W(64)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready_b),
        .wb_inst(wb_inst), .wb_dnpc(wb_dnpc), .wb_kill(wb_kill),
        .wb_invalid(wb_invalid), .wb_device(wb_device),
        .tr_valid(tr_valid_b), .tr_ready(tr_ready),
        .tr_inst(tr_inst_b), .tr_dnpc(tr_dnpc_b), .tr_kill(tr_kill_b),
        .tr_invalid(tr_invalid_b), .tr_device(tr_device_b),
        .retired_cnt(retired_cnt_b), .halted(halted_b)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] dnpc,
                         input logic kill, input logic inv, input logic dev);
        wb_valid = v; wb_inst = inst; wb_dnpc = dnpc;
        wb_kill = kill; wb_invalid = inv; wb_device = dev;
    endtask

    task automatic reset_a();
        rst_n = 1'b0;
        tr_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        check("rst_tr_valid", 128'(tr_valid_a), 128'(0));
        check("rst_cnt", 128'(retired_cnt_a), 128'(0));
        check("rst_halted", 128'(halted_a), 128'(0));
        rst_n = 1'b1;
        #1;
        check("rst_wb_ready", 128'(wb_ready_a), 128'(1));
    endtask

    // Reference model for instance b: a queue of records plus a mode flag.
    rec_t q[$];
    logic m_drain, m_halt;
    logic [63:0] m_cnt;
    rec_t r;

    initial begin
        logic [31:0] insts [3];
        logic [63:0] dnpcs [3];
        logic [4:0]  kill_pat;
        insts[0] = 32'h13;  insts[1] = 32'h93;  insts[2] = 32'h113;
        dnpcs[0] = 64'h80000004; dnpcs[1] = 64'h80000008; dnpcs[2] = 64'h8000000c;
        kill_pat = 5'b01010;

        // 1: three records streamed straight through.
        #2;
        reset_a();
        tick();
        tr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, insts[i], dnpcs[i], 1'b0, 1'b0, 1'b0);
            tick();
            check("s1_valid", 128'(tr_valid_a), 128'(1));
            check("s1_inst", 128'(tr_inst_a), 128'(insts[i]));
            check("s1_dnpc", 128'(tr_dnpc_a), 128'(dnpcs[i]));
        end
        wb_valid = 1'b0;
        tick();
        check("s1_empty", 128'(tr_valid_a), 128'(0));
        check("s1_cnt", 128'(retired_cnt_a), 128'(3));

        // 2: fill to full, then a pop with a refused push.
        reset_a();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 64'(i), 1'b0, 1'b0, 1'b0);
            check("s2_fill_ready", 128'(wb_ready_a), 128'(1));
            tick();
        end
        check("s2_full_ready", 128'(wb_ready_a), 128'(0));
        check("s2_head", 128'(tr_inst_a), 128'(32'h100));
        tr_ready = 1'b1;
        drive(1'b1, 32'hdead, 64'hdead, 1'b0, 1'b0, 1'b0);
        tick();
        tr_ready = 1'b0;
        wb_valid = 1'b0;
        check("s2_ready_back", 128'(wb_ready_a), 128'(1));
        check("s2_head_after_pop", 128'(tr_inst_a), 128'(32'h101));
        check("s2_cnt1", 128'(retired_cnt_a), 128'(1));
        tr_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check("s2_drain_inst", 128'(tr_inst_a), 128'(32'h100 + 32'(i)));
            tick();
        end
        check("s2_drained", 128'(tr_valid_a), 128'(0));
        check("s2_cnt8", 128'(retired_cnt_a), 128'(8));

        // 3: killed records pass through uncounted.
        reset_a();
        tr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h400 + 32'(i), 64'h0, kill_pat[i], 1'b0, 1'b0);
            tick();
            check("s3_inst", 128'(tr_inst_a), 128'(32'h400 + 32'(i)));
            check("s3_kill", 128'(tr_kill_a), 128'(kill_pat[i]));
        end
        wb_valid = 1'b0;
        tick();
        check("s3_cnt", 128'(retired_cnt_a), 128'(3));

        // 4: illegal instruction behind two pending records.
        reset_a();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 64'h0, 1'b0, (i == 2), 1'b0);
            tick();
            if (i == 1) check("s4_ready_before", 128'(wb_ready_a), 128'(1));
        end
        check("s4_ready_drop", 128'(wb_ready_a), 128'(0));
        drive(1'b1, 32'hbad, 64'hbad, 1'b0, 1'b0, 1'b0);
        tr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("s4_valid", 128'(tr_valid_a), 128'(1));
            check("s4_inst", 128'(tr_inst_a), 128'(32'h200 + 32'(i)));
            check("s4_invalid", 128'(tr_invalid_a), 128'(i == 2));
            check("s4_not_halted", 128'(halted_a), 128'(0));
            tick();
        end
        check("s4_empty", 128'(tr_valid_a), 128'(0));
        check("s4_halt_wait", 128'(halted_a), 128'(0));
        tick();
        check("s4_halted", 128'(halted_a), 128'(1));
        check("s4_cnt", 128'(retired_cnt_a), 128'(3));
        for (int i = 0; i < 3; i++) tick();
        check("s4_still_halted", 128'(halted_a), 128'(1));
        check("s4_ignored", 128'(tr_valid_a), 128'(0));
        check("s4_ready_low", 128'(wb_ready_a), 128'(0));
        check("s4_cnt_hold", 128'(retired_cnt_a), 128'(3));

        // 5: asynchronous reset with records queued.
        reset_a();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h300 + 32'(i), 64'h0, 1'b0, 1'b0, i[0]);
            tick();
        end
        wb_valid = 1'b0;
        check("s5_dev0", 128'(tr_device_a), 128'(0));
        tr_ready = 1'b1;
        tick();
        check("s5_dev1", 128'(tr_device_a), 128'(1));
        check("s5_cnt1", 128'(retired_cnt_a), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("s5_async_valid", 128'(tr_valid_a), 128'(0));
        check("s5_async_cnt", 128'(retired_cnt_a), 128'(0));
        check("s5_async_halted", 128'(halted_a), 128'(0));
        tick();
        rst_n = 1'b1;
        drive(1'b1, 32'h777, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        wb_valid = 1'b0;
        check("s5_fresh_valid", 128'(tr_valid_a), 128'(1));
        check("s5_fresh_inst", 128'(tr_inst_a), 128'(32'h777));
        tick();
        check("s5_fresh_empty", 128'(tr_valid_a), 128'(0));
        check("s5_fresh_cnt", 128'(retired_cnt_a), 128'(1));

        // 6: randomized traffic on the DEPTH=4 instance against a queue model.
        rst_n = 1'b0;
        tr_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        q.delete();
        m_drain = 1'b0; m_halt = 1'b0; m_cnt = '0;
        begin
            int halt_cycles;
            halt_cycles = 0;
            for (int cyc = 0; cyc < 10000; cyc++) begin
                logic exp_ready, exp_valid, do_push, do_pop, was_empty;
                int rdy_pct;
                exp_ready = (q.size() < 4) && !m_drain && !m_halt;
                exp_valid = (q.size() > 0) && !m_halt;
                check("rnd_wb_ready", 128'(wb_ready_b), 128'(exp_ready));
                check("rnd_tr_valid", 128'(tr_valid_b), 128'(exp_valid));
                check("rnd_halted", 128'(halted_b), 128'(m_halt));
                check("rnd_cnt", 128'(retired_cnt_b), 128'(m_cnt));
                if (exp_valid) begin
                    check("rnd_head",
                          128'({tr_inst_b, tr_dnpc_b, tr_kill_b, tr_invalid_b, tr_device_b}),
                          128'(q[0]));
                end

                if (m_halt && halt_cycles >= 3) begin
                    rst_n = 1'b0;
                    #1;
                    q.delete();
                    m_drain = 1'b0; m_halt = 1'b0; m_cnt = '0;
                    halt_cycles = 0;
                    tick();
                    rst_n = 1'b1;
                    continue;
                end

                case ((cyc / 256) % 3)
                    0: rdy_pct = 25;
                    1: rdy_pct = 50;
                    default: rdy_pct = 90;
                endcase
                tr_ready = ($urandom_range(99) < rdy_pct);
                drive(($urandom_range(3) != 0), $urandom, {$urandom, $urandom},
                      ($urandom_range(3) == 0), ($urandom_range(299) == 0),
                      $urandom_range(1) == 1);

                do_push = wb_valid && exp_ready;
                do_pop  = exp_valid && tr_ready;
                was_empty = (q.size() == 0);
                r = '{inst: wb_inst, dnpc: wb_dnpc, kill: wb_kill,
                      invalid: wb_invalid, device: wb_device};
                tick();

                if (do_pop) begin
                    if (!q[0].kill) m_cnt++;
                    void'(q.pop_front());
                end
                if (do_push) q.push_back(r);
                if (m_halt) halt_cycles++;
                else if (m_drain && was_empty) begin
                    m_drain = 1'b0;
                    m_halt = 1'b1;
                end else if (do_push && r.invalid) m_drain = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
